// File: rtl/add_arb_pkg.sv
// Shared widths and the round-robin pick helper for the adder request arbiter.
// Optional statistics counters are enabled with the ADD_ARB_STATS_EN macro.
package add_arb_pkg;

  localparam int OPND_W     = 9;
  localparam int RES_W      = 10;
  localparam int DATA_IN_W  = OPND_W;
  localparam int DATA_OUT_W = RES_W;
  localparam int MAX_REQ    = 8;

  // Index of the first set bit of valid at or after ptr, wrapping within n entries.
  // The caller qualifies the result with |valid.
  function automatic logic [2:0] rr_pick_idx(input logic [MAX_REQ-1:0] valid,
                                             input logic [2:0] ptr,
                                             input logic [3:0] n);
    logic [2:0] sel;
    logic       hit;
    logic [3:0] idx;
    sel = ptr;
    hit = 1'b0;
    for (int k = 0; k < MAX_REQ; k++) begin
      idx = {1'b0, ptr} + 4'(k);
      if (idx >= n) idx = idx - n;
      if (!hit && (4'(k) < n) && valid[idx[2:0]]) begin
        sel = idx[2:0];
        hit = 1'b1;
      end
    end
    return sel;
  endfunction

endpackage

// File: rtl/add_arb_tag_fifo.sv
// In-order tag FIFO recording which requester owns each op in flight in the adder.
// DEPTH must be a power of two, at least 2.
module add_arb_tag_fifo import add_arb_pkg::*; #(
  parameter int DEPTH = 8,
  parameter int W     = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [W-1:0]           din,
  input  logic                   pop,
  output logic [W-1:0]           dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic          do_push, do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/add_req_arbiter.sv
// Round-robin arbiter sharing one 9+9->10-bit adder among NUM_REQ requesters,
// routing results back in order. Define ADD_ARB_STATS_EN for per-requester grant counters.
module add_req_arbiter import add_arb_pkg::*; #(
  parameter int NUM_REQ    = 4,
  parameter int MAX_OUTSTD = 8
`ifdef ADD_ARB_STATS_EN
  , parameter int CNT_W    = 16
`endif
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           req_valid,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic [NUM_REQ*DATA_IN_W-1:0] req_data0,
  input  logic [NUM_REQ*DATA_IN_W-1:0] req_data1,
  output logic [DATA_IN_W-1:0]         add_data0,
  output logic [DATA_IN_W-1:0]         add_data1,
  output logic                         add_valid,
  input  logic [DATA_OUT_W-1:0]        add_res_data,
  input  logic                         add_res_valid,
  output logic [NUM_REQ-1:0]           rsp_valid,
  output logic [DATA_OUT_W-1:0]        rsp_data,
  output logic [$clog2(MAX_OUTSTD):0]  outstd,
  output logic                         err_orphan
`ifdef ADD_ARB_STATS_EN
  , output logic [NUM_REQ*CNT_W-1:0]   grant_cnt
`endif
);
  localparam int TAG_W = $clog2(NUM_REQ);
  localparam int OC_W  = $clog2(MAX_OUTSTD) + 1;

  logic [TAG_W-1:0] rr_ptr, gnt_idx, head_tag;
  logic             full, empty, push, pop, fifo_full;

  // Full is judged on the registered count only, so a same-cycle pop never frees a slot early.
  assign full    = (outstd == OC_W'(MAX_OUTSTD));
  assign gnt_idx = TAG_W'(rr_pick_idx(MAX_REQ'(req_valid), 3'(rr_ptr), 4'(NUM_REQ)));
  assign push    = ~full & (|req_valid);
  assign pop     = add_res_valid & ~empty;

  always_comb begin
    req_ready = '0;
    if (push) req_ready[gnt_idx] = 1'b1;
  end

  add_arb_tag_fifo #(.DEPTH(MAX_OUTSTD), .W(TAG_W)) u_tag_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (gnt_idx),
    .pop   (pop),
    .dout  (head_tag),
    .full  (fifo_full),
    .empty (empty),
    .count (outstd)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr     <= '0;
      add_valid  <= 1'b0;
      add_data0  <= '0;
      add_data1  <= '0;
      rsp_valid  <= '0;
      rsp_data   <= '0;
      err_orphan <= 1'b0;
    end else begin
      add_valid <= push;
      if (push) begin
        add_data0 <= req_data0[gnt_idx*DATA_IN_W +: DATA_IN_W];
        add_data1 <= req_data1[gnt_idx*DATA_IN_W +: DATA_IN_W];
        rr_ptr    <= (gnt_idx == TAG_W'(NUM_REQ-1)) ? '0 : gnt_idx + 1'b1;
      end
      rsp_valid <= pop ? (NUM_REQ'(1) << head_tag) : '0;
      if (pop) rsp_data <= add_res_data;
      // Results with no tag belong to ops issued before a reset; drop and flag them.
      if (add_res_valid && empty) err_orphan <= 1'b1;
    end
  end

`ifdef ADD_ARB_STATS_EN
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_cnt
    logic [CNT_W-1:0] cnt;
    always_ff @(posedge clk) begin
      if (rst)                             cnt <= '0;
      else if (req_ready[i] && cnt != '1)  cnt <= cnt + 1'b1;
    end
    assign grant_cnt[i*CNT_W +: CNT_W] = cnt;
  end
`endif

endmodule

// File: tb/tb_add_req_arbiter.sv
// Self-checking bench for add_req_arbiter: directed tables, corner sequences and random
// traffic against a queue-based reference model. Grant-counter checks need ADD_ARB_STATS_EN.
module tb_add_req_arbiter;
  localparam int N    = 4;
  localparam int MAXO = 8;
`ifdef ADD_ARB_STATS_EN
  localparam int CW   = 4;
`endif

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_valid, req_ready, rsp_valid;
  logic [N*9-1:0] req_data0, req_data1;
  logic [8:0]     add_data0, add_data1;
  logic           add_valid, add_res_valid, err_orphan;
  logic [9:0]     add_res_data, rsp_data;
  logic [3:0]     outstd;
`ifdef ADD_ARB_STATS_EN
  logic [N*CW-1:0] grant_cnt;
`endif

  always #5 clk = ~clk;

  add_req_arbiter #(.NUM_REQ(N), .MAX_OUTSTD(MAXO)
`ifdef ADD_ARB_STATS_EN
    , .CNT_W(CW)
`endif
  ) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_data0(req_data0), .req_data1(req_data1),
    .add_data0(add_data0), .add_data1(add_data1), .add_valid(add_valid),
    .add_res_data(add_res_data), .add_res_valid(add_res_valid),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .outstd(outstd), .err_orphan(err_orphan)
`ifdef ADD_ARB_STATS_EN
    , .grant_cnt(grant_cnt)
`endif
  );

  int checks = 0;
  int errors = 0;

  // Reference model: queue of owner indices plus the expected registered outputs.
  int         q[$];
  int         ptr;
  logic       e_av, e_err;
  logic [8:0] e_d0, e_d1;
  logic [N-1:0] e_rsp;
  logic [9:0] e_rd;
  int         gcnt[N];

  typedef struct {
    logic [N-1:0] valid;
    logic         res_valid;
    logic [N-1:0] exp_ready;
    logic [N-1:0] exp_rsp;
  } vec_t;
  vec_t tbl[11];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [N-1:0] m_grant();
    if (q.size() >= MAXO) return '0;
    for (int k = 0; k < N; k++) begin
      int i = (ptr + k) % N;
      if (req_valid[i]) return N'(1) << i;
    end
    return '0;
  endfunction

  task automatic m_reset();
    q.delete();
    ptr = 0; e_av = 0; e_err = 0; e_d0 = '0; e_d1 = '0; e_rsp = '0; e_rd = '0;
    for (int i = 0; i < N; i++) gcnt[i] = 0;
  endtask

  // One clock: compare everything at the falling edge, advance the model, then step past the rise.
  task automatic cycle();
    logic [N-1:0] g;
    @(negedge clk);
    g = m_grant();
    chk("req_ready", req_ready, g);
    chk("add_valid", add_valid, e_av);
    chk("add_data0", add_data0, e_d0);
    chk("add_data1", add_data1, e_d1);
    chk("rsp_valid", rsp_valid, e_rsp);
    if (e_rsp != '0) chk("rsp_data", rsp_data, e_rd);
    chk("outstd", outstd, q.size());
    chk("err_orphan", err_orphan, e_err);
`ifdef ADD_ARB_STATS_EN
    for (int i = 0; i < N; i++) chk("grant_cnt", grant_cnt[i*CW +: CW], gcnt[i]);
`endif
    if (rst) m_reset();
    else begin
      e_rsp = '0;
      if (add_res_valid) begin
        if (q.size() > 0) begin
          int t = q.pop_front();
          e_rsp = N'(1) << t;
          e_rd  = add_res_data;
        end else e_err = 1'b1;
      end
      e_av = (g != '0);
      for (int i = 0; i < N; i++) if (g[i]) begin
        q.push_back(i);
        e_d0 = req_data0[i*9 +: 9];
        e_d1 = req_data1[i*9 +: 9];
        ptr  = (i + 1) % N;
`ifdef ADD_ARB_STATS_EN
        if (gcnt[i] < (1 << CW) - 1) gcnt[i]++;
`endif
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; req_valid = '0; add_res_valid = 1'b0;
    cycle();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; req_valid = '0; add_res_valid = 1'b0; add_res_data = '0;
    req_data0 = '0; req_data1 = '0;
    @(posedge clk); #1;
    m_reset();
    rst = 1'b0;
    #1;
    chk("reset_add_valid", add_valid, 1'b0);
    chk("reset_rsp_valid", rsp_valid, '0);
    chk("reset_outstd", outstd, 0);
    chk("reset_err", err_orphan, 1'b0);

    // Single requester pass-through.
    req_data0[18 +: 9] = 9'h1FF; req_data1[18 +: 9] = 9'h001;
    req_valid = 4'b0100;
    #1 chk("t1_ready", req_ready, 4'b0100);
    cycle();
    chk("t1_add_valid", add_valid, 1'b1);
    chk("t1_add_data0", add_data0, 9'h1FF);
    chk("t1_add_data1", add_data1, 9'h001);
    req_valid = '0; add_res_valid = 1'b1; add_res_data = 10'h200;
    cycle();
    add_res_valid = 1'b0;
    chk("t1_rsp_valid", rsp_valid, 4'b0100);
    chk("t1_rsp_data", rsp_data, 10'h200);
    cycle();

    // All four requesting: strict 0,1,2,3 rotation and in-order routing.
    tbl[0]  = '{4'hF, 1'b0, 4'b0001, 4'b0000};
    tbl[1]  = '{4'hF, 1'b1, 4'b0010, 4'b0000};
    tbl[2]  = '{4'hF, 1'b1, 4'b0100, 4'b0001};
    tbl[3]  = '{4'hF, 1'b1, 4'b1000, 4'b0010};
    tbl[4]  = '{4'hF, 1'b1, 4'b0001, 4'b0100};
    tbl[5]  = '{4'hF, 1'b1, 4'b0010, 4'b1000};
    tbl[6]  = '{4'hF, 1'b1, 4'b0100, 4'b0001};
    tbl[7]  = '{4'hF, 1'b1, 4'b1000, 4'b0010};
    tbl[8]  = '{4'h0, 1'b1, 4'b0000, 4'b0100};
    tbl[9]  = '{4'h0, 1'b0, 4'b0000, 4'b1000};
    tbl[10] = '{4'h0, 1'b0, 4'b0000, 4'b0000};
    do_reset();
    for (int r = 0; r < 11; r++) begin
      req_valid = tbl[r].valid; add_res_valid = tbl[r].res_valid;
      add_res_data = 10'($urandom); req_data0 = {N{9'($urandom)}}; req_data1 = {N{9'($urandom)}};
      #1;
      chk("t2_ready", req_ready, tbl[r].exp_ready);
      chk("t2_rsp_valid", rsp_valid, tbl[r].exp_rsp);
      cycle();
    end

    // Fill to MAX_OUTSTD, then a return at full must not grant in the same cycle.
    do_reset();
    req_valid = 4'hF; add_res_valid = 1'b0;
    repeat (10) cycle();
    chk("t3_outstd_full", outstd, 4'd8);
    chk("t3_ready_full", req_ready, 4'b0000);
    add_res_valid = 1'b1; add_res_data = 10'h155;
    #1 chk("t4_ready_pop_cycle", req_ready, 4'b0000);
    cycle();
    add_res_valid = 1'b0;
    chk("t4_ready_next", req_ready, 4'b0001);
    chk("t4_outstd_7", outstd, 4'd7);
    cycle();
    chk("t3_outstd_refill", outstd, 4'd8);
    chk("t3_ready_blocked", req_ready, 4'b0000);
    add_res_valid = 1'b1;
    repeat (3) cycle();
    req_valid = '0;
    repeat (9) cycle();
    add_res_valid = 1'b0;
    cycle();

    // Reset with ops in flight: later results are orphans.
    do_reset();
    req_valid = 4'hF;
    repeat (3) cycle();
    do_reset();
    add_res_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("t5_rsp_none", rsp_valid, 4'b0000);
      chk("t5_err_sticky", err_orphan, 1'b1);
    end
    add_res_valid = 1'b0;
    cycle();

`ifdef ADD_ARB_STATS_EN
    do_reset();
    req_valid = 4'b0010;
    for (int i = 0; i < 22; i++) begin
      add_res_valid = (q.size() > 0);
      cycle();
    end
    chk("t6_cnt_sat", grant_cnt[CW +: CW], 4'd15);
    do_reset();
    chk("t6_cnt_clear", grant_cnt[CW +: CW], 4'd0);
`endif

    // Random traffic against the model.
    do_reset();
    for (int i = 0; i < 500; i++) begin
      req_valid     = N'($urandom);
      req_data0     = {9'($urandom), 9'($urandom), 9'($urandom), 9'($urandom)};
      req_data1     = {9'($urandom), 9'($urandom), 9'($urandom), 9'($urandom)};
      add_res_data  = 10'($urandom);
      add_res_valid = ($urandom_range(0, 2) != 0) && (q.size() > 0 || $urandom_range(0, 30) == 0);
      rst           = ($urandom_range(0, 99) == 0);
      cycle();
    end
    rst = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
